// File: rtl/lsu_tag_array_pkg.sv
// Shared definitions for the LSU data-cache tag stage.
//   - request/response bundles (lsu_tag_req_t, lsu_tag_rsp_t)
//   - tag-stage FSM state type
//   - geometry derivation helpers (offset/set/tag widths)
//   - address-split helpers and the default I/O base constant
package lsu_tag_array_pkg;

  localparam logic [31:0] LsuMmioBase = 32'hF000_0000;

  typedef struct packed {
    logic [31:0] addr;
    logic        load;
    logic        store;
    logic        invalidate;
  } lsu_tag_req_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        load;
    logic        store;
    logic        invalidate;
    logic        io;
  } lsu_tag_rsp_t;

  typedef enum logic [0:0] {StClear, StReady} lsu_tag_state_e;

  function automatic int unsigned offset_bits_f(input int unsigned line_bytes);
    return $clog2(line_bytes);
  endfunction

  function automatic int unsigned set_bits_f(input int unsigned num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int unsigned tag_bits_f(input int unsigned line_bytes,
                                             input int unsigned num_sets);
    return 32 - offset_bits_f(line_bytes) - set_bits_f(num_sets);
  endfunction

  // Set index, right-aligned; caller narrows to its set width.
  function automatic logic [31:0] addr_set_f(input logic [31:0]  addr,
                                             input int unsigned off_bits,
                                             input int unsigned set_bits);
    return (addr >> off_bits) & ((32'd1 << set_bits) - 32'd1);
  endfunction

  // Tag, right-aligned; caller narrows to its tag width.
  function automatic logic [31:0] addr_tag_f(input logic [31:0]  addr,
                                             input int unsigned off_bits,
                                             input int unsigned set_bits);
    return addr >> (off_bits + set_bits);
  endfunction

  function automatic logic is_io_f(input logic [31:0] addr, input logic [31:0] base);
    return (addr & base) == base;
  endfunction

endpackage

// File: rtl/lsu_plru_tree.sv
// Per-set tree pseudo-LRU state for the tag stage (used when LSU_TAG_PLRU_EN is defined).
// Ports:
//   clk_i, rst_ni              clock, async active-low reset (all trees cleared to 0)
//   touch_a_*                  first touch (response hit)
//   touch_b_*                  second touch (tag install), applied after touch_a
//   lookup_set_i/victim_way_o  victim way found by walking the tree of a set
// Node bit 0 = victim lies in the left (lower) subtree, 1 = right; nodes are heap-ordered.
module lsu_plru_tree
  import lsu_tag_array_pkg::*;
#(
  parameter int unsigned NUM_WAYS = 4,
  parameter int unsigned NUM_SETS = 64,
  localparam int unsigned WayBits = $clog2(NUM_WAYS),
  localparam int unsigned SetBits = set_bits_f(NUM_SETS)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               touch_a_en_i,
  input  logic [SetBits-1:0] touch_a_set_i,
  input  logic [WayBits-1:0] touch_a_way_i,
  input  logic               touch_b_en_i,
  input  logic [SetBits-1:0] touch_b_set_i,
  input  logic [WayBits-1:0] touch_b_way_i,
  input  logic [SetBits-1:0] lookup_set_i,
  output logic [WayBits-1:0] victim_way_o
);

  localparam int unsigned NodeBits = NUM_WAYS - 1;

  logic [NodeBits-1:0] bits_q [NUM_SETS];
  logic [NodeBits-1:0] bits_d [NUM_SETS];

  // Point every node on the path to `way` away from it.
  function automatic logic [NodeBits-1:0] touch_f(input logic [NodeBits-1:0] b,
                                                  input logic [WayBits-1:0]  way);
    logic [NodeBits-1:0] r;
    logic [WayBits-1:0]  node;
    logic [WayBits-1:0]  w;
    logic                d;
    r    = b;
    node = '0;
    w    = way;
    for (int l = 0; l < int'(WayBits); l++) begin
      d       = w[WayBits-1];
      w       = w << 1;
      r[node] = ~d;
      node    = WayBits'(2 * int'(node) + 1 + int'(d));
    end
    return r;
  endfunction

  function automatic logic [WayBits-1:0] victim_f(input logic [NodeBits-1:0] b);
    logic [WayBits-1:0] v;
    logic [WayBits-1:0] node;
    logic               d;
    v    = '0;
    node = '0;
    for (int l = 0; l < int'(WayBits); l++) begin
      d    = b[node];
      v    = WayBits'({v, d});
      node = WayBits'(2 * int'(node) + 1 + int'(d));
    end
    return v;
  endfunction

  always_comb begin
    for (int s = 0; s < int'(NUM_SETS); s++) begin
      bits_d[s] = bits_q[s];
      if (touch_a_en_i && touch_a_set_i == SetBits'(s)) begin
        bits_d[s] = touch_f(bits_d[s], touch_a_way_i);
      end
      if (touch_b_en_i && touch_b_set_i == SetBits'(s)) begin
        bits_d[s] = touch_f(bits_d[s], touch_b_way_i);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < int'(NUM_SETS); s++) bits_q[s] <= '0;
    end else begin
      bits_q <= bits_d;
    end
  end

  assign victim_way_o = victim_f(bits_q[lookup_set_i]);

endmodule

// File: rtl/lsu_tag_array.sv
// Data-cache tag stage for the LSU: reads all ways' {valid, tag} for the request set and, one
// cycle later, reports hit / hit way / victim way / I/O class to the data stage.
// Configuration macro: LSU_TAG_PLRU_EN selects per-set tree pseudo-LRU replacement; otherwise a
// single global round-robin counter (bumped on each tag install) picks the victim.
// Ports:
//   clk_i, rst_ni           clock, async active-low reset
//   flush_i                 kills the request being accepted and the response being presented
//   req_*                   request handshake, address and one-hot-or-zero op type
//   upd_*                   tag install from the line-fill path (ignored while clearing)
//   evict_set_i/evict_tags_o  writeback tag read, one cycle latency, way 0 in the LSBs
//   rsp_*                   registered request plus hit/victim/I/O classification
module lsu_tag_array
  import lsu_tag_array_pkg::*;
#(
  parameter int unsigned NUM_WAYS   = 4,
  parameter int unsigned NUM_SETS   = 64,
  parameter int unsigned LINE_BYTES = 64,
  parameter logic [31:0] MMIO_BASE  = LsuMmioBase,
  localparam int unsigned WayBits   = $clog2(NUM_WAYS),
  localparam int unsigned SetBits   = set_bits_f(NUM_SETS),
  localparam int unsigned OffBits   = offset_bits_f(LINE_BYTES),
  localparam int unsigned TagBits   = tag_bits_f(LINE_BYTES, NUM_SETS)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush_i,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [31:0]                 req_addr_i,
  input  logic                        req_load_i,
  input  logic                        req_store_i,
  input  logic                        req_invalidate_i,
  input  logic                        upd_en_i,
  input  logic [WayBits-1:0]          upd_way_i,
  input  logic [SetBits-1:0]          upd_set_i,
  input  logic [TagBits-1:0]          upd_tag_i,
  input  logic [SetBits-1:0]          evict_set_i,
  output logic [NUM_WAYS*TagBits-1:0] evict_tags_o,
  output logic                        rsp_valid_o,
  output logic [31:0]                 rsp_addr_o,
  output logic                        rsp_load_o,
  output logic                        rsp_store_o,
  output logic                        rsp_invalidate_o,
  output logic                        rsp_io_o,
  output logic                        rsp_hit_o,
  output logic [WayBits-1:0]          rsp_hit_way_o,
  output logic [WayBits-1:0]          rsp_victim_way_o,
  output logic                        rsp_victim_valid_o
);

  lsu_tag_state_e     state_q;
  logic [SetBits-1:0] clr_set_q;
  logic               req_ready_q;

  lsu_tag_req_t req;
  logic         req_take;
  logic         upd_take;
  logic         clearing;
  logic [SetBits-1:0] req_set;

  assign req      = {req_addr_i, req_load_i, req_store_i, req_invalidate_i};
  assign req_set  = SetBits'(addr_set_f(req_addr_i, OffBits, SetBits));
  assign clearing = (state_q == StClear);
  // A request flushed in its accept cycle has no effect at all, including invalidate.
  assign req_take = req_valid_i && req_ready_q && !flush_i;
  // Walker clears own the write port; installs during a walk are dropped.
  assign upd_take = upd_en_i && !clearing;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StClear;
      clr_set_q   <= '0;
      req_ready_q <= 1'b0;
    end else begin
      unique case (state_q)
        StClear: begin
          if (clr_set_q == SetBits'(NUM_SETS - 1)) begin
            state_q     <= StReady;
            req_ready_q <= 1'b1;
            clr_set_q   <= '0;
          end else begin
            clr_set_q <= clr_set_q + SetBits'(1);
          end
        end
        StReady: begin
          if (req_take && req.invalidate) begin
            state_q     <= StClear;
            req_ready_q <= 1'b0;
            clr_set_q   <= '0;
          end
        end
        default: state_q <= StClear;
      endcase
    end
  end

  assign req_ready_o = req_ready_q;

  // Tag RAM: {valid, tag} per way; one write port, request read and evict read ports.
  logic [TagBits:0]   mem_q   [NUM_WAYS][NUM_SETS];
  logic [TagBits-1:0] evict_q [NUM_WAYS];
  logic [TagBits:0]   rd_a_q  [NUM_WAYS];

  always_ff @(posedge clk_i) begin
    if (clearing) begin
      for (int w = 0; w < int'(NUM_WAYS); w++) mem_q[w][clr_set_q] <= '0;
    end else if (upd_take) begin
      mem_q[upd_way_i][upd_set_i] <= {1'b1, upd_tag_i};
    end
    for (int w = 0; w < int'(NUM_WAYS); w++) begin
      evict_q[w] <= mem_q[w][evict_set_i][TagBits-1:0];
    end
  end

  always_comb begin
    for (int w = 0; w < int'(NUM_WAYS); w++) begin
      evict_tags_o[w*TagBits +: TagBits] = evict_q[w];
    end
  end

  lsu_tag_rsp_t rsp_q;
  logic         rsp_valid_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
      rd_a_q      <= '{default: '0};
    end else begin
      rsp_valid_q <= req_take;
      if (req_take) begin
        rsp_q <= {req, is_io_f(req_addr_i, MMIO_BASE)};
        for (int w = 0; w < int'(NUM_WAYS); w++) begin
          // Same-cycle install to this set must be visible to the response.
          if (upd_take && upd_set_i == req_set && upd_way_i == WayBits'(w)) begin
            rd_a_q[w] <= {1'b1, upd_tag_i};
          end else begin
            rd_a_q[w] <= mem_q[w][req_set];
          end
        end
      end
    end
  end

  logic [TagBits-1:0] rsp_tag;
  logic               hit_any;
  logic [WayBits-1:0] hit_way;
  logic               inv_found;
  logic [WayBits-1:0] inv_way;
  logic [WayBits-1:0] policy_way;
  logic               cacheable;

  assign rsp_tag = TagBits'(addr_tag_f(rsp_q.addr, OffBits, SetBits));

  always_comb begin
    hit_any   = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    // Descending so the lowest invalid way is the last one written.
    for (int w = int'(NUM_WAYS) - 1; w >= 0; w--) begin
      if (!rd_a_q[w][TagBits]) begin
        inv_found = 1'b1;
        inv_way   = WayBits'(w);
      end
      // Matches are one-hot, so OR-ing indices encodes the hit way.
      if (rd_a_q[w][TagBits] && rd_a_q[w][TagBits-1:0] == rsp_tag) begin
        hit_any = 1'b1;
        hit_way = hit_way | WayBits'(w);
      end
    end
  end

  assign cacheable          = !rsp_q.io && (rsp_q.load || rsp_q.store);
  assign rsp_valid_o        = rsp_valid_q && !flush_i;
  assign rsp_addr_o         = rsp_q.addr;
  assign rsp_load_o         = rsp_q.load;
  assign rsp_store_o        = rsp_q.store;
  assign rsp_invalidate_o   = rsp_q.invalidate;
  assign rsp_io_o           = rsp_q.io;
  assign rsp_hit_o          = cacheable && hit_any;
  assign rsp_hit_way_o      = rsp_hit_o ? hit_way : '0;
  assign rsp_victim_way_o   = inv_found ? inv_way : policy_way;
  assign rsp_victim_valid_o = !inv_found;

`ifdef LSU_TAG_PLRU_EN
  logic [SetBits-1:0] rsp_set;
  assign rsp_set = SetBits'(addr_set_f(rsp_q.addr, OffBits, SetBits));

  lsu_plru_tree #(
    .NUM_WAYS (NUM_WAYS),
    .NUM_SETS (NUM_SETS)
  ) u_plru (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .touch_a_en_i  (rsp_valid_o && rsp_hit_o),
    .touch_a_set_i (rsp_set),
    .touch_a_way_i (rsp_hit_way_o),
    .touch_b_en_i  (upd_take),
    .touch_b_set_i (upd_set_i),
    .touch_b_way_i (upd_way_i),
    .lookup_set_i  (rsp_set),
    .victim_way_o  (policy_way)
  );
`else
  logic [WayBits-1:0] rr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= '0;
    end else if (upd_take) begin
      rr_q <= rr_q + WayBits'(1);
    end
  end

  assign policy_way = rr_q;
`endif

endmodule

// File: tb/tb_lsu_tag_array.sv
module tb_lsu_tag_array;

  localparam int unsigned NW = 4;
  localparam int unsigned NS = 64;
  localparam int unsigned TB = 20;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              flush_i;
  logic              req_valid_i;
  logic              req_ready_o;
  logic [31:0]       req_addr_i;
  logic              req_load_i;
  logic              req_store_i;
  logic              req_invalidate_i;
  logic              upd_en_i;
  logic [1:0]        upd_way_i;
  logic [5:0]        upd_set_i;
  logic [TB-1:0]     upd_tag_i;
  logic [5:0]        evict_set_i;
  logic [NW*TB-1:0]  evict_tags_o;
  logic              rsp_valid_o;
  logic [31:0]       rsp_addr_o;
  logic              rsp_load_o;
  logic              rsp_store_o;
  logic              rsp_invalidate_o;
  logic              rsp_io_o;
  logic              rsp_hit_o;
  logic [1:0]        rsp_hit_way_o;
  logic [1:0]        rsp_victim_way_o;
  logic              rsp_victim_valid_o;

  lsu_tag_array #(
    .NUM_WAYS   (NW),
    .NUM_SETS   (NS),
    .LINE_BYTES (64),
    .MMIO_BASE  (32'hF000_0000)
  ) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .flush_i            (flush_i),
    .req_valid_i        (req_valid_i),
    .req_ready_o        (req_ready_o),
    .req_addr_i         (req_addr_i),
    .req_load_i         (req_load_i),
    .req_store_i        (req_store_i),
    .req_invalidate_i   (req_invalidate_i),
    .upd_en_i           (upd_en_i),
    .upd_way_i          (upd_way_i),
    .upd_set_i          (upd_set_i),
    .upd_tag_i          (upd_tag_i),
    .evict_set_i        (evict_set_i),
    .evict_tags_o       (evict_tags_o),
    .rsp_valid_o        (rsp_valid_o),
    .rsp_addr_o         (rsp_addr_o),
    .rsp_load_o         (rsp_load_o),
    .rsp_store_o        (rsp_store_o),
    .rsp_invalidate_o   (rsp_invalidate_o),
    .rsp_io_o           (rsp_io_o),
    .rsp_hit_o          (rsp_hit_o),
    .rsp_hit_way_o      (rsp_hit_way_o),
    .rsp_victim_way_o   (rsp_victim_way_o),
    .rsp_victim_valid_o (rsp_victim_valid_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        valid;
    logic        hit;
    logic [1:0]  hit_way;
    logic [1:0]  victim;
    logic        vv;
    logic        io;
    logic [31:0] addr;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad   = 0;
  logic [1:0] rr_exp = 2'd0;  // round-robin model: installs seen so far, mod 4

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic v, input logic h, input logic [1:0] hw,
                              input logic [1:0] vic, input logic vv, input logic io,
                              input logic [31:0] a);
    exp_t e;
    e.valid = v; e.hit = h; e.hit_way = hw; e.victim = vic; e.vv = vv; e.io = io; e.addr = a;
    return e;
  endfunction

  function automatic logic [31:0] mkaddr(input logic [19:0] tag, input logic [5:0] set);
    return {tag, set, 6'd0};
  endfunction

  task automatic check_rsp();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard observed=empty expected=entry");
    end else begin
      e = sb.pop_front();
      chk("rsp_valid", rsp_valid_o, e.valid);
      if (e.valid) begin
        chk("rsp_addr", rsp_addr_o, e.addr);
        chk("rsp_hit", rsp_hit_o, e.hit);
        chk("rsp_hit_way", rsp_hit_way_o, e.hit_way);
        chk("rsp_victim_way", rsp_victim_way_o, e.victim);
        chk("rsp_victim_valid", rsp_victim_valid_o, e.vv);
        chk("rsp_io", rsp_io_o, e.io);
      end
    end
  endtask

  // Called at a negedge; returns at the negedge of the response cycle.
  task automatic send(input logic [31:0] a, input logic ld, input logic st, input logic inv,
                      input logic fl_acc, input logic fl_rsp, input exp_t e);
    chk("req_ready", req_ready_o, 1'b1);
    sb.push_back(e);
    req_valid_i      = 1'b1;
    req_addr_i       = a;
    req_load_i       = ld;
    req_store_i      = st;
    req_invalidate_i = inv;
    flush_i          = fl_acc;
    @(posedge clk_i);
    #1;
    req_valid_i      = 1'b0;
    req_load_i       = 1'b0;
    req_store_i      = 1'b0;
    req_invalidate_i = 1'b0;
    upd_en_i         = 1'b0;
    flush_i          = fl_rsp;
    @(negedge clk_i);
    check_rsp();
    flush_i = 1'b0;
  endtask

  task automatic upd(input logic [1:0] way, input logic [5:0] set, input logic [19:0] tag);
    upd_en_i  = 1'b1;
    upd_way_i = way;
    upd_set_i = set;
    upd_tag_i = tag;
    rr_exp    = rr_exp + 2'd1;
    @(posedge clk_i);
    #1;
    upd_en_i = 1'b0;
    @(negedge clk_i);
  endtask

  logic [1:0] vic_hits [3];
  logic [1:0] vic_miss;

  initial begin
    int cnt;
`ifdef LSU_TAG_PLRU_EN
    // Tree walk after fills 0..3: victims shown before each hit's own touch.
    vic_hits[0] = 2'd0; vic_hits[1] = 2'd2; vic_hits[2] = 2'd2;
    vic_miss    = 2'd0;
`else
    vic_hits[0] = 2'd0; vic_hits[1] = 2'd0; vic_hits[2] = 2'd0;
    vic_miss    = 2'd0;
`endif
    rst_ni = 1'b0; flush_i = 1'b0; req_valid_i = 1'b0; req_addr_i = '0;
    req_load_i = 1'b0; req_store_i = 1'b0; req_invalidate_i = 1'b0;
    upd_en_i = 1'b0; upd_way_i = '0; upd_set_i = '0; upd_tag_i = '0; evict_set_i = '0;
    repeat (2) @(negedge clk_i);

    chk("reset_req_ready", req_ready_o, 1'b0);
    chk("reset_rsp_valid", rsp_valid_o, 1'b0);
    chk("reset_rsp_hit", rsp_hit_o, 1'b0);
    chk("reset_rsp_addr", rsp_addr_o, 32'd0);
    chk("reset_rsp_io", rsp_io_o, 1'b0);
    chk("reset_rsp_victim_way", rsp_victim_way_o, 2'd0);
    chk("reset_rsp_victim_valid", rsp_victim_valid_o, 1'b0);

    rst_ni = 1'b1;
    cnt = 0;
    while (req_ready_o !== 1'b1 && cnt < 200) begin
      @(negedge clk_i);
      cnt++;
    end
    chk("reset_clear_cycles", cnt, NS);

    send(32'h0000_1000, 1, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 32'h0000_1000));

    // Fill set 5, read tags back over the evict port, then hit ways 0..2 and miss.
    for (int i = 0; i < 4; i++) upd(2'(i), 6'd5, 20'h00100 + 20'(i));
    vic_miss = vic_miss;
    evict_set_i = 6'd5;
    @(negedge clk_i);
    chk("evict_tags_set5", evict_tags_o, {20'h00103, 20'h00102, 20'h00101, 20'h00100});
    for (int i = 0; i < 3; i++) begin
`ifdef LSU_TAG_PLRU_EN
      send(mkaddr(20'h00100 + 20'(i), 6'd5), 1, 0, 0, 0, 0,
           mk(1, 1, 2'(i), vic_hits[i], 1, 0, mkaddr(20'h00100 + 20'(i), 6'd5)));
`else
      send(mkaddr(20'h00100 + 20'(i), 6'd5), 1, 0, 0, 0, 0,
           mk(1, 1, 2'(i), rr_exp, 1, 0, mkaddr(20'h00100 + 20'(i), 6'd5)));
`endif
    end
`ifdef LSU_TAG_PLRU_EN
    send(mkaddr(20'h00200, 6'd5), 1, 0, 0, 0, 0,
         mk(1, 0, 0, vic_miss, 1, 0, mkaddr(20'h00200, 6'd5)));
`else
    send(mkaddr(20'h00200, 6'd5), 1, 0, 0, 0, 0,
         mk(1, 0, 0, rr_exp, 1, 0, mkaddr(20'h00200, 6'd5)));
`endif

    // Install way 2 of set 0x10, then hit it.
    upd(2'd2, 6'h10, 20'hABCDE);
    send(32'hABCD_E400, 1, 0, 0, 0, 0, mk(1, 1, 2, 0, 0, 0, 32'hABCD_E400));

    // Same-cycle install and request to that set.
    upd_en_i = 1'b1; upd_way_i = 2'd1; upd_set_i = 6'h22; upd_tag_i = 20'h12345;
    rr_exp = rr_exp + 2'd1;
    send(32'h1234_5880, 1, 0, 0, 0, 0, mk(1, 1, 1, 0, 0, 0, 32'h1234_5880));

    // I/O address whose tag is present: classified I/O, never a hit.
    upd(2'd0, 6'd4, 20'hF0000);
    send(32'hF000_0100, 1, 0, 0, 0, 0, mk(1, 0, 0, 1, 0, 1, 32'hF000_0100));

    // Flushed hits must not surface or move replacement state.
    send(mkaddr(20'h00100, 6'd5), 1, 0, 0, 1, 0, mk(0, 0, 0, 0, 0, 0, 32'd0));
    send(mkaddr(20'h00100, 6'd5), 1, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 32'd0));
`ifdef LSU_TAG_PLRU_EN
    send(mkaddr(20'h00300, 6'd5), 1, 0, 0, 0, 0,
         mk(1, 0, 0, 2'd0, 1, 0, mkaddr(20'h00300, 6'd5)));
    send(mkaddr(20'h00101, 6'd5), 0, 1, 0, 0, 0,
         mk(1, 1, 1, 2'd0, 1, 0, mkaddr(20'h00101, 6'd5)));
`else
    send(mkaddr(20'h00300, 6'd5), 1, 0, 0, 0, 0,
         mk(1, 0, 0, rr_exp, 1, 0, mkaddr(20'h00300, 6'd5)));
    send(mkaddr(20'h00101, 6'd5), 0, 1, 0, 0, 0,
         mk(1, 1, 1, rr_exp, 1, 0, mkaddr(20'h00101, 6'd5)));
`endif

    // Invalidate: response next cycle, then a full walk with ready low.
    send(32'hABCD_E400, 0, 0, 1, 0, 0, mk(1, 0, 0, 0, 0, 0, 32'hABCD_E400));
    chk("inval_rsp_invalidate", rsp_invalidate_o, 1'b1);
    cnt = 0;
    while (req_ready_o !== 1'b1 && cnt < 200) begin
      cnt++;
      @(negedge clk_i);
    end
    chk("inval_ready_low_cycles", cnt, NS);
    chk("evict_tags_after_clear", evict_tags_o, {(NW * TB){1'b0}});
    send(32'hABCD_E400, 1, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 32'hABCD_E400));

    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

endmodule
